uart_rx_param: RTL and testbench

//   Parametrised UART receiver, successor to the fixed 8N1 receiver.
//   - Configurable data width, oversampling, parity and stop bits; 3-sample majority vote per bit.
//   - Frames go out through a one-entry valid/ready holding register, with framing, parity and overrun flags.
//   - Sits between the board RX pin and a consumer (FIFO, decoder, LED logic).

---
 rtl/uart_rx_param_if.sv | 25 ++
 rtl/uart_rx_param.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bus: received word, error flags and a valid/ready handshake.
// The master side (receiver) drives data, flags, overrun and busy; the slave side
// (consumer) drives dout_ready. Ports: dout[WL], dout_valid, dout_ready, frame_err,
// parity_err, overrun, busy.
interface uart_rx_param_if #(
  parameter int WL = 8
);
  logic [WL-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  modport master (
    output dout, dout_valid, frame_err, parity_err, overrun, busy,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_valid, frame_err, parity_err, overrun, busy,
    output dout_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Purpose: parametrised UART receiver (WL data bits, optional parity, 1/2 stop bits,
//   OVS-times oversampling with a 3-sample majority vote per bit).
// Latency: frame handed over at the mid point of the last stop bit, plus 2 CLK of
//   synchroniser and up to one tick period of phase.
// Backpressure: one-entry holding register; a frame completing while the previous one
//   is still unaccepted is dropped and flagged with a one-cycle overrun pulse.
// Ports: CLK, RST_N (async, active low), din (raw serial line, idle high),
//   bus (master modport: dout, dout_valid, dout_ready, frame_err, parity_err, overrun, busy).
module uart_rx_param #(
  parameter int WL         = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             din,
  uart_rx_param_if.master  bus
);

  // Clock cycles per oversampling tick; must come out at 2 or more.
  localparam int DIV = CLK_FREQ / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW = $clog2(OVS);
  localparam int BCW = (WL > 1) ? $clog2(WL) : 1;

  localparam logic [DW-1:0]  DIV_LAST     = DW'(DIV - 1);
  localparam logic [SCW-1:0] SC_LAST      = SCW'(OVS - 1);
  localparam logic [SCW-1:0] SC_S0        = SCW'(OVS / 2 - 1);
  localparam logic [SCW-1:0] SC_S1        = SCW'(OVS / 2);
  localparam logic [SCW-1:0] SC_MID       = SCW'(OVS / 2 + 1);
  localparam logic [BCW-1:0] BC_LAST      = BCW'(WL - 1);
  localparam logic [BCW-1:0] BC_STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic           PEN          = (PARITY_EN != 0);
  localparam logic           PODD         = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser (resets to the idle-high line level)
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_rxs;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= din;
      r_rxs   <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running oversampling tick
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_div_cnt;
  logic          w_tick;

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM and output holding register
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [SCW-1:0]  r_sc;
  logic [BCW-1:0]  r_bc;
  logic [WL-1:0]   r_shift;
  logic            r_v0;
  logic            r_v1;
  logic            r_ferr;
  logic            r_perr;
  logic [WL-1:0]   r_dout;
  logic            r_valid;
  logic            r_ferr_o;
  logic            r_perr_o;
  logic            r_overrun;

  logic            w_vote;
  logic            w_mid;
  logic            w_end;
  logic [SCW-1:0]  w_sc_next;

  // Third sample is the live line value at the mid point; the first two were latched
  // on the preceding ticks.
  assign w_vote    = (r_v0 & r_v1) | (r_v0 & r_rxs) | (r_v1 & r_rxs);
  assign w_mid     = w_tick && (r_sc == SC_MID);
  assign w_end     = w_tick && (r_sc == SC_LAST);
  assign w_sc_next = (r_sc == SC_LAST) ? '0 : r_sc + SCW'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_sc      <= '0;
      r_bc      <= '0;
      r_shift   <= '0;
      r_v0      <= 1'b1;
      r_v1      <= 1'b1;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_perr_o  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;

      // Consumer accept; a completion later in this block overrides the clear.
      if (r_valid && bus.dout_ready) begin
        r_valid <= 1'b0;
      end

      if (w_tick) begin
        if (r_state != S_IDLE) begin
          r_sc <= w_sc_next;
          if (r_sc == SC_S0) r_v0 <= r_rxs;
          if (r_sc == SC_S1) r_v1 <= r_rxs;
        end

        unique case (r_state)
          S_IDLE: begin
            if (!r_rxs) begin
              r_state <= S_START;
              r_sc    <= '0;
              r_ferr  <= 1'b0;
              r_perr  <= 1'b0;
            end
          end

          S_START: begin
            if (w_mid && w_vote) begin
              // Line back high at mid start bit: noise, not a frame.
              r_state <= S_IDLE;
              r_sc    <= '0;
            end else if (w_end) begin
              r_state <= S_DATA;
              r_bc    <= '0;
            end
          end

          S_DATA: begin
            if (w_mid) begin
              r_shift <= {w_vote, r_shift[WL-1:1]};
            end
            if (w_end) begin
              if (r_bc == BC_LAST) begin
                r_state <= PEN ? S_PARITY : S_STOP;
                r_bc    <= '0;
              end else begin
                r_bc <= r_bc + BCW'(1);
              end
            end
          end

          S_PARITY: begin
            if (w_mid) begin
              r_perr <= ((^r_shift) ^ w_vote) != PODD;
            end
            if (w_end) begin
              r_state <= S_STOP;
              r_bc    <= '0;
            end
          end

          S_STOP: begin
            if (w_mid && (r_bc == BC_STOP_LAST)) begin
              // Finish half a bit early so a back-to-back start edge is not missed.
              r_state <= S_IDLE;
              r_sc    <= '0;
              if (!r_valid || bus.dout_ready) begin
                r_dout   <= r_shift;
                r_ferr_o <= r_ferr | ~w_vote;
                r_perr_o <= r_perr;
                r_valid  <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              if (w_mid) begin
                r_ferr <= r_ferr | ~w_vote;
              end
              if (w_end) begin
                r_bc <= r_bc + BCW'(1);
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.frame_err  = r_ferr_o;
  assign bus.parity_err = r_perr_o;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one 8N1 receiver and one 8E1 receiver driven
// from separate serial lines, 160 CLK per bit.
module tb_uart_rx_param;

  localparam int BITCLK = 160;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic din_n = 1'b1;
  logic din_p = 1'b1;

  always #5 CLK = ~CLK;

  uart_rx_param_if #(.WL(8)) bus_n ();
  uart_rx_param_if #(.WL(8)) bus_p ();

  uart_rx_param #(
    .WL(8), .CLK_FREQ(1_600_000), .BAUD(10_000), .OVS(16),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_n (
    .CLK(CLK), .RST_N(RST_N), .din(din_n), .bus(bus_n.master)
  );

  uart_rx_param #(
    .WL(8), .CLK_FREQ(1_600_000), .BAUD(10_000), .OVS(16),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_p (
    .CLK(CLK), .RST_N(RST_N), .din(din_p), .bus(bus_p.master)
  );

  int checks = 0;
  int errors = 0;

  // Transfer monitors, sampled on the falling edge
  int         xfer_n = 0;
  int         xfer_p = 0;
  int         vcyc_n = 0;
  int         ovr_n  = 0;
  logic [7:0] last_n = '0;
  logic [7:0] last_p = '0;
  logic       lferr_n = 1'b0;
  logic       lperr_n = 1'b0;
  logic       lferr_p = 1'b0;
  logic       lperr_p = 1'b0;

  always @(negedge CLK) begin
    if (bus_n.dout_valid) vcyc_n <= vcyc_n + 1;
    if (bus_n.overrun)    ovr_n  <= ovr_n + 1;
    if (bus_n.dout_valid && bus_n.dout_ready) begin
      xfer_n  <= xfer_n + 1;
      last_n  <= bus_n.dout;
      lferr_n <= bus_n.frame_err;
      lperr_n <= bus_n.parity_err;
    end
    if (bus_p.dout_valid && bus_p.dout_ready) begin
      xfer_p  <= xfer_p + 1;
      last_p  <= bus_p.dout;
      lferr_p <= bus_p.frame_err;
      lperr_p <= bus_p.parity_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_n(input logic [7:0] d, input logic sb);
    din_n = 1'b0;
    tick(BITCLK);
    for (int i = 0; i < 8; i++) begin
      din_n = d[i];
      tick(BITCLK);
    end
    din_n = sb;
    tick(BITCLK);
    din_n = 1'b1;
  endtask

  task automatic send_p(input logic [7:0] d, input logic pb);
    din_p = 1'b0;
    tick(BITCLK);
    for (int i = 0; i < 8; i++) begin
      din_p = d[i];
      tick(BITCLK);
    end
    din_p = pb;
    tick(BITCLK);
    din_p = 1'b1;
    tick(BITCLK);
  endtask

  int base_x;
  int base_v;
  int base_o;

  initial begin
    bus_n.dout_ready = 1'b1;
    bus_p.dout_ready = 1'b1;

    // Reset state
    tick(4);
    chk("rst_valid_n", bus_n.dout_valid, 0);
    chk("rst_dout_n",  bus_n.dout,       8'h00);
    chk("rst_ferr_n",  bus_n.frame_err,  0);
    chk("rst_perr_n",  bus_n.parity_err, 0);
    chk("rst_ovr_n",   bus_n.overrun,    0);
    chk("rst_busy_n",  bus_n.busy,       0);
    chk("rst_valid_p", bus_p.dout_valid, 0);
    chk("rst_busy_p",  bus_p.busy,       0);
    RST_N = 1'b1;
    tick(2 * BITCLK);

    // 8N1 0xA5, consumer always ready
    send_n(8'hA5, 1'b1);
    tick(20);
    chk("a5_xfer",  xfer_n,  1);
    chk("a5_dout",  last_n,  8'hA5);
    chk("a5_ferr",  lferr_n, 0);
    chk("a5_perr",  lperr_n, 0);
    chk("a5_vcyc",  vcyc_n,  1);
    chk("a5_busy",  bus_n.busy, 0);
    chk("a5_valid", bus_n.dout_valid, 0);

    // Even parity: 0x07 has three ones, so a parity bit of 0 is wrong
    send_p(8'h07, 1'b0);
    chk("par_bad_xfer", xfer_p,  1);
    chk("par_bad_dout", last_p,  8'h07);
    chk("par_bad_perr", lperr_p, 1);
    chk("par_bad_ferr", lferr_p, 0);
    send_p(8'h07, 1'b1);
    chk("par_ok_xfer",  xfer_p,  2);
    chk("par_ok_perr",  lperr_p, 0);

    // Stop bit held low, then a clean frame after some idle
    send_n(8'h3C, 1'b0);
    tick(2 * BITCLK);
    chk("ferr_xfer", xfer_n,  2);
    chk("ferr_dout", last_n,  8'h3C);
    chk("ferr_flag", lferr_n, 1);
    send_n(8'h55, 1'b1);
    tick(20);
    chk("clean_xfer", xfer_n,  3);
    chk("clean_dout", last_n,  8'h55);
    chk("clean_ferr", lferr_n, 0);

    // Overrun: consumer stalled across two back-to-back frames
    bus_n.dout_ready = 1'b0;
    base_o = ovr_n;
    base_x = xfer_n;
    send_n(8'h11, 1'b1);
    chk("ovr_first_valid", bus_n.dout_valid, 1);
    chk("ovr_no_pulse_yet", ovr_n - base_o, 0);
    send_n(8'h22, 1'b1);
    tick(20);
    chk("ovr_count", ovr_n - base_o, 1);
    chk("ovr_hold_dout", bus_n.dout, 8'h11);
    chk("ovr_hold_valid", bus_n.dout_valid, 1);
    chk("ovr_pulse_gone", bus_n.overrun, 0);
    bus_n.dout_ready = 1'b1;
    tick(1);
    chk("ovr_drain_valid", bus_n.dout_valid, 0);
    tick(1);
    chk("ovr_drain_xfer", xfer_n - base_x, 1);
    chk("ovr_drain_dout", last_n, 8'h11);

    // Short low glitch on the line
    tick(BITCLK);
    base_x = xfer_n;
    base_v = vcyc_n;
    din_n = 1'b0;
    tick(40);
    din_n = 1'b1;
    chk("glitch_busy_on", bus_n.busy, 1);
    tick(BITCLK);
    chk("glitch_busy_off", bus_n.busy, 0);
    chk("glitch_no_valid", vcyc_n - base_v, 0);
    chk("glitch_no_xfer", xfer_n - base_x, 0);

    // Reset in the middle of the data bits of 0xFF, then 0x81
    tick(BITCLK);
    base_x = xfer_n;
    base_v = vcyc_n;
    din_n = 1'b0;
    tick(BITCLK);
    din_n = 1'b1;
    tick(400);
    chk("cut_busy_before", bus_n.busy, 1);
    RST_N = 1'b0;
    tick(3);
    chk("cut_busy_rst", bus_n.busy, 0);
    chk("cut_valid_rst", bus_n.dout_valid, 0);
    RST_N = 1'b1;
    tick(4 * BITCLK);
    chk("cut_no_valid", vcyc_n - base_v, 0);
    send_n(8'h81, 1'b1);
    tick(20);
    chk("after_cut_xfer", xfer_n - base_x, 1);
    chk("after_cut_dout", last_n, 8'h81);
    chk("after_cut_ferr", lferr_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
